// File: rtl/sevenseg_scan_driver.sv
// Latches a 4-digit packed BCD word and time-multiplexes it onto a common-anode
// 7-segment display. Define LZ_BLANK_EN to enable leading-zero blanking.
module sevenseg_scan_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = 17
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_bcd,
  input  logic [3:0]  i_dp_in,
  input  logic        i_load,
  output logic [3:0]  o_an,
  output logic [6:0]  o_seg,
  output logic        o_dp,
  output logic        o_busy_frame
);

  localparam logic [CNT_W-1:0] LP_PRESC_LAST = CNT_W'(REFRESH_DIV - 1);

  // Active-low {g,f,e,d,c,b,a}; anything outside 0..9 shows a dash.
  function automatic logic [6:0] f_decode(input logic [3:0] nib);
    case (nib)
      4'd0:    f_decode = 7'b1000000;
      4'd1:    f_decode = 7'b1111001;
      4'd2:    f_decode = 7'b0100100;
      4'd3:    f_decode = 7'b0110000;
      4'd4:    f_decode = 7'b0011001;
      4'd5:    f_decode = 7'b0010010;
      4'd6:    f_decode = 7'b0000010;
      4'd7:    f_decode = 7'b1111000;
      4'd8:    f_decode = 7'b0000000;
      4'd9:    f_decode = 7'b0010000;
      default: f_decode = 7'b0111111;
    endcase
  endfunction

  logic [15:0]      r_bcd;
  logic [3:0]       r_dp;
  logic [CNT_W-1:0] r_presc;
  logic [1:0]       r_idx;

  logic             w_adv;
  logic [3:0]       w_lz;
  logic [3:0]       w_nib;
  logic             w_dp_bit;
  logic [3:0]       w_an;
  logic             w_blank;
  logic [6:0]       w_seg;

  assign w_adv = (r_presc == LP_PRESC_LAST);

`ifdef LZ_BLANK_EN
  logic [3:0] w_nz;
  // Invalid nibbles are non-zero, so they stop the blanking run.
  assign w_nz = {|r_bcd[15:12], |r_bcd[11:8], |r_bcd[7:4], |r_bcd[3:0]};
  assign w_lz = {~w_nz[3], ~(|w_nz[3:2]), ~(|w_nz[3:1]), 1'b0};
`else
  assign w_lz = 4'b0000;
`endif

  // Holding registers: only a load strobe lets upstream data through.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bcd <= 16'h0000;
      r_dp  <= 4'b0000;
    end else if (i_load) begin
      r_bcd <= i_bcd;
      r_dp  <= i_dp_in;
    end else begin
      r_bcd <= r_bcd;
      r_dp  <= r_dp;
    end
  end

  // Prescaler and digit index.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_presc <= {CNT_W{1'b0}};
      r_idx   <= 2'd0;
    end else if (w_adv) begin
      r_presc <= {CNT_W{1'b0}};
      r_idx   <= r_idx + 2'd1;
    end else begin
      r_presc <= r_presc + CNT_W'(1);
      r_idx   <= r_idx;
    end
  end

  // Select the current digit's nibble, decimal point, anode and blanking.
  always_comb begin
    w_nib    = 4'd0;
    w_dp_bit = 1'b0;
    w_an     = 4'b1111;
    w_blank  = 1'b0;
    case (r_idx)
      2'd0: begin
        w_nib = r_bcd[3:0];   w_dp_bit = r_dp[0]; w_an = 4'b1110; w_blank = w_lz[0];
      end
      2'd1: begin
        w_nib = r_bcd[7:4];   w_dp_bit = r_dp[1]; w_an = 4'b1101; w_blank = w_lz[1];
      end
      2'd2: begin
        w_nib = r_bcd[11:8];  w_dp_bit = r_dp[2]; w_an = 4'b1011; w_blank = w_lz[2];
      end
      2'd3: begin
        w_nib = r_bcd[15:12]; w_dp_bit = r_dp[3]; w_an = 4'b0111; w_blank = w_lz[3];
      end
      default: begin
        w_nib = 4'd0; w_dp_bit = 1'b0; w_an = 4'b1111; w_blank = 1'b0;
      end
    endcase
  end

  assign w_seg = w_blank ? 7'b1111111 : f_decode(w_nib);

  // Registered pin drivers; busy_frame marks the cycle after the 3->0 wrap.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_an         <= 4'b1111;
      o_seg        <= 7'b1111111;
      o_dp         <= 1'b1;
      o_busy_frame <= 1'b0;
    end else begin
      o_an         <= w_an;
      o_seg        <= w_seg;
      o_dp         <= ~w_dp_bit;
      o_busy_frame <= w_adv && (r_idx == 2'd3);
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Directed self-checking bench for sevenseg_scan_driver with REFRESH_DIV=4.
module tb_sevenseg_scan_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] bcd = 16'h0000;
  logic [3:0]  dp_in = 4'b0000;
  logic        load = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        busy_frame;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                         S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000,
                         S9 = 7'b0010000, SDASH = 7'b0111111, SBLK = 7'b1111111;

`ifdef LZ_BLANK_EN
  localparam logic [6:0] SLZ = SBLK;
`else
  localparam logic [6:0] SLZ = S0;
`endif

  sevenseg_scan_driver #(.REFRESH_DIV(4), .CNT_W(3)) dut (
    .i_clk(clk), .i_rst(rst), .i_bcd(bcd), .i_dp_in(dp_in), .i_load(load),
    .o_an(an), .o_seg(seg), .o_dp(dp), .o_busy_frame(busy_frame)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    bcd = v; dp_in = d; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  // Advance at least one cycle, then until digit d is driven (bounded).
  task automatic wait_digit(input int d);
    logic [3:0] want;
    bit found;
    want = ~(4'b0001 << d);
    found = 1'b0;
    tick();
    for (int i = 0; i < 40 && !found; i++) begin
      if (an === want) found = 1'b1;
      else tick();
    end
    if (!found) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_digit%0d: an=%b never reached %b", d, an, want);
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_busy;
    int dig;
    rst = 1'b1;
    repeat (3) tick();
    n_checks++; if (an !== 4'b1111) begin n_fail++; $display("FAIL reset_an: got %b want 1111", an); end
    n_checks++; if (seg !== SBLK) begin n_fail++; $display("FAIL reset_seg: got %b want %b", seg, SBLK); end
    n_checks++; if (dp !== 1'b1) begin n_fail++; $display("FAIL reset_dp: got %b want 1", dp); end
    n_checks++; if (busy_frame !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_frame); end
    rst = 1'b0;
    for (int s = 1; s <= 32; s++) begin
      tick();
      dig      = ((s - 1) / 4) % 4;
      exp_an   = ~(4'b0001 << dig);
      exp_seg  = (dig == 0) ? S0 : SLZ;
      exp_busy = ((s % 16) == 0);
      n_checks++; if (an !== exp_an) begin n_fail++; $display("FAIL scan_an s=%0d: got %b want %b", s, an, exp_an); end
      n_checks++; if (seg !== exp_seg) begin n_fail++; $display("FAIL scan_seg s=%0d: got %b want %b", s, seg, exp_seg); end
      n_checks++; if (busy_frame !== exp_busy) begin n_fail++; $display("FAIL scan_busy s=%0d: got %b want %b", s, busy_frame, exp_busy); end
    end
  endtask

  task automatic test_load_1234();
    logic [6:0] es [4] = '{S4, S3, S2, S1};
    logic       ed [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    do_load(16'h1234, 4'b0100);
    for (int d = 0; d < 4; d++) begin
      wait_digit(d);
      n_checks++; if (seg !== es[d]) begin n_fail++; $display("FAIL l1234_seg d%0d: got %b want %b", d, seg, es[d]); end
      n_checks++; if (dp !== ed[d]) begin n_fail++; $display("FAIL l1234_dp d%0d: got %b want %b", d, dp, ed[d]); end
    end
  endtask

  task automatic test_decode();
    logic [6:0] es [4] = '{S6, S7, S8, S9};
    logic       ed [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    do_load(16'h9876, 4'b1001);
    for (int d = 0; d < 4; d++) begin
      wait_digit(d);
      n_checks++; if (seg !== es[d]) begin n_fail++; $display("FAIL dec_seg d%0d: got %b want %b", d, seg, es[d]); end
      n_checks++; if (dp !== ed[d]) begin n_fail++; $display("FAIL dec_dp d%0d: got %b want %b", d, dp, ed[d]); end
    end
  endtask

  task automatic test_invalid();
    logic [6:0] es [4] = '{SDASH, SDASH, SLZ, SLZ};
    do_load(16'h00AF, 4'b0000);
    for (int d = 0; d < 4; d++) begin
      wait_digit(d);
      n_checks++; if (seg !== es[d]) begin n_fail++; $display("FAIL inval_seg d%0d: got %b want %b", d, seg, es[d]); end
      n_checks++; if (dp !== 1'b1) begin n_fail++; $display("FAIL inval_dp d%0d: got %b want 1", d, dp); end
    end
  endtask

  task automatic test_lz();
    logic [6:0] ez [4] = '{S0, SLZ, SLZ, SLZ};
    logic [6:0] ef [4] = '{S5, S0, S1, SLZ};
    do_load(16'h0000, 4'b1000);
    for (int d = 0; d < 4; d++) begin
      wait_digit(d);
      n_checks++; if (seg !== ez[d]) begin n_fail++; $display("FAIL lz0000_seg d%0d: got %b want %b", d, seg, ez[d]); end
    end
    // Blanked digit 3 still carries its decimal point.
    n_checks++; if (dp !== 1'b0) begin n_fail++; $display("FAIL lz0000_dp3: got %b want 0", dp); end
    do_load(16'h0105, 4'b0000);
    for (int d = 0; d < 4; d++) begin
      wait_digit(d);
      n_checks++; if (seg !== ef[d]) begin n_fail++; $display("FAIL lz0105_seg d%0d: got %b want %b", d, seg, ef[d]); end
    end
  endtask

  task automatic test_load_isolation();
    logic [6:0] es [4] = '{S8, S7, S6, S5};
    do_load(16'h5678, 4'b0000);
    bcd = 16'h9999; dp_in = 4'b1111;
    repeat (16) tick();
    for (int d = 0; d < 4; d++) begin
      wait_digit(d);
      n_checks++; if (seg !== es[d]) begin n_fail++; $display("FAIL iso_seg d%0d: got %b want %b", d, seg, es[d]); end
      n_checks++; if (dp !== 1'b1) begin n_fail++; $display("FAIL iso_dp d%0d: got %b want 1", d, dp); end
    end
  endtask

  task automatic test_midscan_reset();
    do_load(16'h4321, 4'b1111);
    wait_digit(2);
    rst = 1'b1;
    tick();
    n_checks++; if (an !== 4'b1111) begin n_fail++; $display("FAIL mrst_an: got %b want 1111", an); end
    n_checks++; if (seg !== SBLK) begin n_fail++; $display("FAIL mrst_seg: got %b want %b", seg, SBLK); end
    n_checks++; if (dp !== 1'b1) begin n_fail++; $display("FAIL mrst_dp: got %b want 1", dp); end
    rst = 1'b0;
    tick();
    n_checks++; if (an !== 4'b1110) begin n_fail++; $display("FAIL mrst_rel_an: got %b want 1110", an); end
    n_checks++; if (seg !== S0) begin n_fail++; $display("FAIL mrst_rel_seg: got %b want %b", seg, S0); end
    n_checks++; if (dp !== 1'b1) begin n_fail++; $display("FAIL mrst_rel_dp: got %b want 1", dp); end
    tick();
    tick();
    // Load lands on the same edge the index advances to digit 1.
    bcd = 16'h0020; dp_in = 4'b0010; load = 1'b1;
    tick();
    load = 1'b0;
    n_checks++; if (an !== 4'b1110) begin n_fail++; $display("FAIL adv_pre_an: got %b want 1110", an); end
    n_checks++; if (seg !== S0) begin n_fail++; $display("FAIL adv_pre_seg: got %b want %b", seg, S0); end
    tick();
    n_checks++; if (an !== 4'b1101) begin n_fail++; $display("FAIL adv_an: got %b want 1101", an); end
    n_checks++; if (seg !== S2) begin n_fail++; $display("FAIL adv_seg: got %b want %b", seg, S2); end
    n_checks++; if (dp !== 1'b0) begin n_fail++; $display("FAIL adv_dp: got %b want 0", dp); end
  endtask

  initial begin
    test_reset();
    test_load_1234();
    test_decode();
    test_invalid();
    test_lz();
    test_load_isolation();
    test_midscan_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sevenseg_scan_driver.md
Name: sevenseg_scan_driver

Overview:
- Downstream consumer of the 16-bit packed BCD word produced by the binary-to-BCD converter.
- Latches the 4-digit BCD value and time-multiplexes it onto a common-anode 4-digit 7-segment display.
- Drives active-low anodes and segments, decoding one nibble per scan slot.
- Sits between the combinational BCD converter and the board pins; all outputs are registered.

Parameters:
REFRESH_DIV, 100000, clock cycles per digit slot (must be >= 2); the full frame is 4*REFRESH_DIV cycles
CNT_W, 17, prescaler width; must satisfy 2^CNT_W >= REFRESH_DIV

Ports:
clk  input  1  system clock; all logic on the rising edge
rst  input  1  synchronous, active-high reset
bcd  input  16  packed BCD: [3:0] ones, [7:4] tens, [11:8] hundreds, [15:12] thousands
dp_in  input  4  decimal-point request per digit, bit i = digit i, 1 = lit
load  input  1  single-cycle strobe; capture bcd and dp_in
an  output  4  anode enables, active low, an[i] = digit i (digit 0 = ones)
seg  output  7  segments {g,f,e,d,c,b,a}, active low
dp  output  1  decimal-point segment, active low
busy_frame  output  1  pulses high for 1 cycle when the scan wraps from digit 3 to digit 0

Behaviour:
- One clock; reset is synchronous and active-high (clk, rst).
- Reset state:
  - an=4'b1111, seg=7'b1111111, dp=1, busy_frame=0.
  - Internal: latched bcd=0, latched dp=0, prescaler=0, digit index=0.
- Reset mid-scan returns to exactly this state on the next edge; no partial frame continues.
- Latch:
  - On an edge with load=1 and rst=0, bcd and dp_in are captured into holding registers.
  - load=0 holds the previous value.
  - Inputs are ignored while load=0, so upstream glitches never reach the display.
- Prescaler:
  - Counts 0..REFRESH_DIV-1, then wraps to 0.
  - On the edge where prescaler==REFRESH_DIV-1, the digit index advances 0->1->2->3->0.
- busy_frame: high for the single cycle following the 3->0 index transition.
- Output register (updated every cycle from the current index and latch):
  - an = all ones except bit[index]=0.
  - seg = decode(latched nibble[index]).
  - dp = ~latched_dp[index].
  - Latency: index or latch change at edge k appears on an/seg/dp at edge k+1.
  - A load landing in the same cycle as a digit advance: the new digit uses the new latch value, one cycle later, per the rule above.
- The first cycle after reset release shows an=4'b1110 with digit 0 content.
- Decode (active low, {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Nibbles 10..15 are invalid and display a dash: seg=0111111 (only g lit).
- Only one anode is low at any time; never two, and never none except during reset.

Optional Feature:
- Macro LZ_BLANK_EN: leading-zero blanking.
- When defined:
  - Digits 3..1 are blanked (seg=1111111, dp follows latched dp) if that digit and every higher digit are 0.
  - The anode still scans, so timing is unchanged.
  - Digit 0 is never blanked.
  - Invalid nibbles (>9) count as non-zero.
- When undefined: all four digits are always shown, including leading zeros.

Test Plan:
- Reset and scan, REFRESH_DIV=4: hold rst 3 cycles, release -> an=1110 for 4 cycles, then 1101, 1011, 0111, 1110; busy_frame pulses once per 16 cycles.
- Load 16'h1234 with dp_in=4'b0100 -> digit0 seg=0011001 ("4"), digit1=0110000, digit2=0100100 with dp=0, digit3=1111001.
- Invalid nibble: load 16'h00AF -> digits 0 and 1 show 0111111; digits 2 and 3 show 1000000 (macro off) or blank 1111111 (LZ_BLANK_EN).
- LZ_BLANK_EN, load 16'h0000 -> digit0 shows 1000000; digits 1-3 show 1111111. Load 16'h0105 -> only digit 3 blank.
- Load isolation: load 16'h5678, then change bcd to 16'h9999 with load=0 for a full frame -> display stays 5678.
- Mid-scan reset: assert rst while index=2 -> next edge gives an=1111 and seg=1111111; latch cleared to 0000 after release.
